mmio_responder: RTL and testbench

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder.sv | 119 +++++++++++
 tb/tb_mmio_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped I/O window: LED, switch, key-edge and (with MMIO_TIMER_EN defined) timer registers.
// rdata is registered to match RAM read latency; offset 2 is clear-on-read.
module mmio_responder #(
    parameter logic [7:0]  BASE_ADDR = 8'hF0,
    parameter int unsigned TICK_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  address,
    input  logic        mwrite,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        hit,
    input  logic [9:0]  sw,
    input  logic [2:0]  key_n,
    output logic [6:0]  ledr
);
    logic [3:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  key_fall;

    logic [15:0] rdata_d, rdata_q;
    logic [6:0]  led_d, led_q;
    logic [9:0]  sw_s1_d, sw_s1_q, sw_s2_d, sw_s2_q;
    logic [2:0]  key_s1_d, key_s1_q, key_s2_d, key_s2_q, key_dly_d, key_dly_q;
    logic [2:0]  key_edge_d, key_edge_q;

`ifdef MMIO_TIMER_EN
    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    logic [15:0] presc_d, presc_q;
    logic [15:0] timer_d, timer_q;
    logic        tick;
`else
    logic        unused_wdata;
    assign unused_wdata = ^wdata[15:7];
`endif

    assign hit    = (address[7:4] == BASE_ADDR[7:4]);
    assign offset = address[3:0];
    assign wr_en  = hit & mwrite;
    assign rd_en  = hit & ~mwrite;
    assign rdata  = rdata_q;
    assign ledr   = led_q;

    always_comb begin
        led_d = led_q;
        if (wr_en && offset == 4'd0)
            led_d = wdata[6:0];

        sw_s1_d   = sw;
        sw_s2_d   = sw_s1_q;
        key_s1_d  = key_n;
        key_s2_d  = key_s1_q;
        key_dly_d = key_s2_q;

        // A fresh fall overrides a coincident read-clear so no press is lost.
        key_fall   = key_dly_q & ~key_s2_q;
        key_edge_d = ((rd_en && offset == 4'd2) ? 3'b000 : key_edge_q) | key_fall;

        rdata_d = 16'h0000;
        if (hit) begin
            case (offset)
                4'd0:    rdata_d = {9'b0, led_q};
                4'd1:    rdata_d = {6'b0, sw_s2_q};
                4'd2:    rdata_d = {13'b0, key_edge_q};
`ifdef MMIO_TIMER_EN
                4'd3:    rdata_d = timer_q;
`endif
                default: rdata_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q    <= 16'h0000;
            led_q      <= 7'h00;
            sw_s1_q    <= 10'h000;
            sw_s2_q    <= 10'h000;
            key_s1_q   <= 3'b111;
            key_s2_q   <= 3'b111;
            key_dly_q  <= 3'b111;
            key_edge_q <= 3'b000;
        end else begin
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_dly_q  <= key_dly_d;
            key_edge_q <= key_edge_d;
        end
    end

`ifdef MMIO_TIMER_EN
    // A CPU load takes priority over a coincident tick and restarts the prescaler.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? 16'h0000 : presc_q + 16'h0001;
        timer_d = tick ? timer_q + 16'h0001 : timer_q;
        if (wr_en && offset == 4'd3) begin
            presc_d = 16'h0000;
            timer_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'h0000;
            timer_q <= 16'h0000;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
        end
    end
`endif
endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: expected rdata is queued at issue time and
// compared one clock later; timer behaviour is checked when MMIO_TIMER_EN is defined.
module tb_mmio_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  address = 8'h00;
    logic        mwrite = 1'b0;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        hit;
    logic [9:0]  sw = 10'h000;
    logic [2:0]  key_n = 3'b111;
    logic [6:0]  ledr;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_r;
    logic        last_hit;

    mmio_responder #(.BASE_ADDR(8'hF0), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .address(address), .mwrite(mwrite), .wdata(wdata),
        .rdata(rdata), .hit(hit), .sw(sw), .key_n(key_n), .ledr(ledr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle; the expected registered read data is queued before the edge.
    task automatic access(input logic [7:0] a, input logic w, input logic [15:0] d,
                          input logic [15:0] e);
        address = a;
        mwrite  = w;
        wdata   = d;
        sb_q.push_back(e);
        #1;
        last_hit = hit;
        @(posedge clk);
        #1;
        address = 8'h00;
        mwrite  = 1'b0;
        wdata   = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        n_checks++; if (ledr !== 7'h00) begin n_fail++; $display("FAIL reset_ledr got=%h exp=00", ledr); end
        #1 reset = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            access(8'hF0 + 8'(i), 1'b0, 16'h0, 16'h0000);
            exp_r = sb_q.pop_front();
            n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL reset_read off=%0d got=%h exp=%h", i, rdata, exp_r); end
        end
    endtask

    task automatic test_led();
        access(8'hF0, 1'b1, 16'h0055, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL led_wr_old got=%h exp=%h", rdata, exp_r); end
        n_checks++; if (ledr !== 7'h55) begin n_fail++; $display("FAIL led_ledr got=%h exp=55", ledr); end
        access(8'hF0, 1'b0, 16'h0, 16'h0055);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL led_rd got=%h exp=%h", rdata, exp_r); end
        access(8'hF0, 1'b1, 16'hFFAA, 16'h0055);
        exp_r = sb_q.pop_front();
        access(8'hF0, 1'b0, 16'h0, 16'h002A);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL led_mask got=%h exp=%h", rdata, exp_r); end
    endtask

    task automatic test_sw();
        sw = 10'h3A5;
        idle(3);
        access(8'hF1, 1'b0, 16'h0, 16'h03A5);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL sw_rd got=%h exp=%h", rdata, exp_r); end
        sw = 10'h05A;
        access(8'hF1, 1'b0, 16'h0, 16'h03A5);
        access(8'hF1, 1'b0, 16'h0, 16'h03A5);
        access(8'hF1, 1'b0, 16'h0, 16'h005A);
        for (int i = 0; i < 3; i++) begin
            exp_r = sb_q.pop_front();
            // all three reads were issued back to back; only the last result is still on rdata
            if (i == 2) begin
                n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL sw_sync got=%h exp=%h", rdata, exp_r); end
            end
        end
        sw = 10'h05A;
        access(8'hF1, 1'b1, 16'hFFFF, 16'h005A);
        exp_r = sb_q.pop_front();
        access(8'hF1, 1'b0, 16'h0, 16'h005A);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL sw_ro got=%h exp=%h", rdata, exp_r); end
    endtask

    task automatic test_sw_latency();
        sw = 10'h2C3;
        access(8'hF1, 1'b0, 16'h0, 16'h005A);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL sw_lat1 got=%h exp=%h", rdata, exp_r); end
        access(8'hF1, 1'b0, 16'h0, 16'h005A);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL sw_lat2 got=%h exp=%h", rdata, exp_r); end
        access(8'hF1, 1'b0, 16'h0, 16'h02C3);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL sw_lat3 got=%h exp=%h", rdata, exp_r); end
    endtask

    task automatic test_keyedge();
        key_n = 3'b101;
        idle(5);
        key_n = 3'b111;
        idle(4);
        access(8'hF2, 1'b0, 16'h0, 16'h0002);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_set got=%h exp=%h", rdata, exp_r); end
        access(8'hF2, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_clr got=%h exp=%h", rdata, exp_r); end
        key_n = 3'b110;
        idle(4);
        access(8'hF2, 1'b0, 16'h0, 16'h0001);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_hold1 got=%h exp=%h", rdata, exp_r); end
        idle(3);
        access(8'hF2, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_hold_once got=%h exp=%h", rdata, exp_r); end
        key_n = 3'b111;
        idle(4);
        access(8'hF2, 1'b1, 16'hFFFF, 16'h0000);
        exp_r = sb_q.pop_front();
        access(8'hF2, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_release_wr got=%h exp=%h", rdata, exp_r); end
        // set bit 1, then land a second fall exactly on the read-clear edge
        key_n = 3'b101;
        idle(4);
        key_n = 3'b111;
        idle(4);
        key_n = 3'b101;
        idle(2);
        access(8'hF2, 1'b0, 16'h0, 16'h0002);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_coinc_rd got=%h exp=%h", rdata, exp_r); end
        access(8'hF2, 1'b0, 16'h0, 16'h0002);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_coinc_keep got=%h exp=%h", rdata, exp_r); end
        access(8'hF2, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL key_coinc_clr got=%h exp=%h", rdata, exp_r); end
        key_n = 3'b111;
        idle(4);
    endtask

    task automatic test_unmapped();
        access(8'hF7, 1'b1, 16'h1111, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (last_hit !== 1'b1) begin n_fail++; $display("FAIL unm_hit got=%b exp=1", last_hit); end
        access(8'hF7, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL unm_rd got=%h exp=%h", rdata, exp_r); end
        access(8'h10, 1'b1, 16'h007F, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (last_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit got=%b exp=0", last_hit); end
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL miss_rd got=%h exp=%h", rdata, exp_r); end
        n_checks++; if (ledr !== 7'h2A) begin n_fail++; $display("FAIL miss_ledr got=%h exp=2a", ledr); end
        key_n = 3'b011;
        idle(4);
        key_n = 3'b111;
        idle(3);
        access(8'h12, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        access(8'hF2, 1'b0, 16'h0, 16'h0004);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL miss_noclr got=%h exp=%h", rdata, exp_r); end
        access(8'hF2, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
    endtask

    task automatic test_reset_mid();
        n_checks++; if (ledr !== 7'h2A) begin n_fail++; $display("FAIL mid_pre_ledr got=%h exp=2a", ledr); end
        key_n   = 3'b011;
        idle(1);
        address = 8'hF0;
        mwrite  = 1'b1;
        wdata   = 16'h007F;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ledr !== 7'h00) begin n_fail++; $display("FAIL mid_ledr got=%h exp=00", ledr); end
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rdata got=%h exp=0000", rdata); end
        key_n = 3'b111;
        idle(2);
        n_checks++; if (ledr !== 7'h00) begin n_fail++; $display("FAIL mid_wr_abort got=%h exp=00", ledr); end
        address = 8'h00;
        mwrite  = 1'b0;
        wdata   = 16'h0000;
        reset   = 1'b0;
        idle(4);
        access(8'hF2, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL mid_edge got=%h exp=%h", rdata, exp_r); end
        access(8'hF0, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL mid_led got=%h exp=%h", rdata, exp_r); end
    endtask

    task automatic test_timer();
        do_reset();
`ifdef MMIO_TIMER_EN
        access(8'hF3, 1'b1, 16'hFFFF, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL tmr_old got=%h exp=%h", rdata, exp_r); end
        idle(3);
        access(8'hF3, 1'b0, 16'h0, 16'hFFFF);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL tmr_pre_tick got=%h exp=%h", rdata, exp_r); end
        access(8'hF3, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL tmr_wrap got=%h exp=%h", rdata, exp_r); end
        access(8'hF3, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        access(8'hF3, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL tmr_hold got=%h exp=%h", rdata, exp_r); end
        access(8'hF3, 1'b1, 16'h1234, 16'h0000);
        exp_r = sb_q.pop_front();
        access(8'hF3, 1'b0, 16'h0, 16'h1234);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL tmr_wr_wins got=%h exp=%h", rdata, exp_r); end
        access(8'hF3, 1'b0, 16'h0, 16'h1234);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL tmr_presc_clr got=%h exp=%h", rdata, exp_r); end
`else
        access(8'hF3, 1'b1, 16'hABCD, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (last_hit !== 1'b1) begin n_fail++; $display("FAIL f3_hit got=%b exp=1", last_hit); end
        idle(6);
        access(8'hF3, 1'b0, 16'h0, 16'h0000);
        exp_r = sb_q.pop_front();
        n_checks++; if (rdata !== exp_r) begin n_fail++; $display("FAIL f3_unmapped got=%h exp=%h", rdata, exp_r); end
`endif
    endtask

    initial begin
        test_reset();
        test_led();
        test_sw();
        test_sw_latency();
        test_keyedge();
        test_unmapped();
        test_reset_mid();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
